// File: rtl/path_launch_tester.sv
// Launch-side at-speed path tester: drives LFSR V1/V2 pairs into a path under test and
// checks the response CAP_DLY edges after each launch. Optional macro: STOP_ON_FAIL_EN.
module path_launch_tester #(
    parameter int               WIDTH     = 8,
    parameter int               NUM_PAIRS = 16,
    parameter int               CAP_DLY   = 2,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1)
) (
    input  logic             C,
    input  logic             RN,
    input  logic             START,
    output logic [WIDTH-1:0] PUT_IN,
    input  logic [WIDTH-1:0] PUT_OUT,
    input  logic [WIDTH-1:0] GOLD,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [15:0]      ERR_CNT,
    output logic [15:0]      FAIL_IDX
);

    localparam int               CNT_W     = (CAP_DLY > 1) ? $clog2(CAP_DLY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CAP_DLY - 1);
    localparam logic [15:0]      PAIR_LAST = 16'(NUM_PAIRS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_LAUNCH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] put_in_q, put_in_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      pair_q, pair_d;
    logic             first_q, first_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [15:0]      err_q, err_d;
    logic [15:0]      fidx_q, fidx_d;
    logic             mismatch;
    logic             last_pair;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1] ^ v[WIDTH-2]};
    endfunction

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        put_in_d  = put_in_q;
        cnt_d     = cnt_q;
        pair_d    = pair_q;
        first_d   = first_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        mismatch  = 1'b0;
        last_pair = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_INIT;
                    busy_d  = 1'b1;
                    err_d   = 16'h0000;
                    fidx_d  = 16'hFFFF;
                    pass_d  = 1'b0;
                    lfsr_d  = SEED;
                    pair_d  = 16'h0000;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end

            ST_INIT: begin
                // The edge after the start edge loads V1 of pair 0; later V1 loads happen at capture.
                if (first_q) begin
                    put_in_d = lfsr_q;
                    lfsr_d   = lfsr_step(lfsr_q);
                    first_d  = 1'b0;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_LAST) begin
                    put_in_d = lfsr_q;
                    lfsr_d   = lfsr_step(lfsr_q);
                    cnt_d    = '0;
                    state_d  = ST_LAUNCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_LAUNCH: begin
                if (cnt_q == CNT_LAST) begin
                    // Case inequality so an X response is scored as a miss.
                    mismatch = (PUT_OUT !== GOLD);
                    if (mismatch) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (fidx_q == 16'hFFFF) fidx_d = pair_q;
                    end
                    cnt_d = '0;
`ifdef STOP_ON_FAIL_EN
                    last_pair = (pair_q == PAIR_LAST) || mismatch;
`else
                    last_pair = (pair_q == PAIR_LAST);
`endif
                    if (last_pair) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 16'h0000);
                    end else begin
                        put_in_d = lfsr_q;
                        lfsr_d   = lfsr_step(lfsr_q);
                        pair_d   = pair_q + 16'd1;
                        state_d  = ST_INIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            put_in_q <= '0;
            cnt_q    <= '0;
            pair_q   <= 16'h0000;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 16'h0000;
            fidx_q   <= 16'hFFFF;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            put_in_q <= put_in_d;
            cnt_q    <= cnt_d;
            pair_q   <= pair_d;
            first_q  <= first_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fidx_q   <= fidx_d;
        end
    end

    assign PUT_IN   = put_in_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_IDX = fidx_q;

endmodule

// File: doc/path_launch_tester.md
Name: path_launch_tester

Overview:
- Launch-side partner to the DFF capture cell, for at-speed path checks on a combinational path under test (PUT).
- Drives pairs of registered vectors (init V1, then launch V2) onto the PUT inputs.
- Samples the PUT response a fixed number of clock edges after the V1→V2 launch edge and compares it against a golden value.
- Counts mismatches and reports pass/fail, so gate-level netlists built from the timed cell library can be screened for paths that miss the capture window.

Parameters:
- WIDTH, 8, bit width of PUT input and output vectors (>=2).
- NUM_PAIRS, 16, number of V1/V2 transition pairs per run (>=1).
- CAP_DLY, 2, clock edges from a vector load to the next event; used both for V1 settle time and for the launch-to-capture window (>=1).
- SEED, 8'h01, nonzero LFSR seed (WIDTH bits).

Ports:
- C, input, 1, clock; all state updates on posedge.
- RN, input, 1, asynchronous active-low reset.
- START, input, 1, run request; sampled only in IDLE.
- PUT_IN, output, WIDTH, registered vector driven into the path under test.
- PUT_OUT, input, WIDTH, response of the path under test.
- GOLD, input, WIDTH, expected response for the current launch vector, supplied by the environment.
- BUSY, output, 1, high from the run start edge until the final capture edge.
- DONE, output, 1, one-cycle pulse after the final capture.
- PASS, output, 1, ERR_CNT==0 at end of run; held until the next START.
- ERR_CNT, output, 16, mismatch count, saturating at 16'hFFFF.
- FAIL_IDX, output, 16, index of the first failing pair; 16'hFFFF if no pair has failed.

Behaviour:
- Reset (RN low, asynchronous), all outputs forced immediately:
  - PUT_IN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_IDX=16'hFFFF.
  - State=IDLE, LFSR=SEED, pair index=0.
  - A reset mid-run aborts the run with no DONE pulse.
- LFSR: L(0)=SEED; L(n+1)={L(n)[WIDTH-2:0], L(n)[WIDTH-1]^L(n)[WIDTH-2]}.
  - Pair i uses V1=L(2i) and V2=L(2i+1).
  - LFSR is reloaded with SEED on every run start.
- States: IDLE → INIT → LAUNCH → (INIT | IDLE).
- Edge numbering: edge S is the edge that samples START=1 in IDLE.
  - At S: BUSY<=1, ERR_CNT<=0, FAIL_IDX<=FFFF, PASS<=0, state<=INIT.
  - At S+1: PUT_IN<=V1 of pair 0.
- INIT: V1 is held for CAP_DLY edges; on the CAP_DLY-th edge PUT_IN<=V2 and state<=LAUNCH. That edge is the launch edge.
- LAUNCH: V2 is held. On the CAP_DLY-th edge after the launch edge (the capture edge):
  - PUT_OUT is compared with GOLD.
  - On mismatch: ERR_CNT increments (saturating), and FAIL_IDX<=pair index if FAIL_IDX==FFFF.
  - If pairs remain: PUT_IN<=V1 of the next pair and state<=INIT.
  - If this was the last pair: state<=IDLE, BUSY<=0, DONE<=1 for one cycle, and PASS<=(final ERR_CNT==0), including the result of this capture.
- Total run length: DONE is high in the cycle after edge S+1+2*NUM_PAIRS*CAP_DLY.
- Comparison uses the PUT_OUT/GOLD values present at the capture edge; no extra input registering.
- PUT_IN holds the last V2 while in IDLE.
- START while BUSY=1 is ignored.
- START held high continuously restarts a run on the first IDLE cycle after DONE.
- X on PUT_OUT at a capture counts as a mismatch (case-inequality compare).

Optional Feature:
- Macro: STOP_ON_FAIL_EN.
- Defined: on the first mismatching capture, the run ends at that edge. State<=IDLE, BUSY<=0, DONE pulses, PASS=0, ERR_CNT=1, and FAIL_IDX=that pair. Remaining pairs are skipped.
- Undefined: all NUM_PAIRS pairs always run; behaviour is exactly as above.

Test Plan:
- Reset mid-run (RN low at LAUNCH of pair 2) → all outputs at reset values asynchronously, no DONE pulse; a new START gives PUT_IN=8'h01 at S+1.
- NUM_PAIRS=4, CAP_DLY=2, bench drives PUT_OUT=GOLD=PUT_IN → PUT_IN sequence 01,02,04,08,10,20,40,81, each held 2 cycles; DONE after edge S+17; PASS=1, ERR_CNT=0, FAIL_IDX=FFFF.
- Same config, PUT_OUT=GOLD except pairs 1 and 3, which capture PUT_OUT=GOLD^8'h01 → ERR_CNT=2, FAIL_IDX=1, PASS=0.
- Same config with STOP_ON_FAIL_EN, mismatch on pair 1 → DONE after edge S+9; ERR_CNT=1, FAIL_IDX=1, PUT_IN stays 8'h08.
- START pulsed while BUSY=1 → ignored; run length and results unchanged. A second START after DONE → ERR_CNT cleared and LFSR restarts at 8'h01.
- CAP_DLY=1, NUM_PAIRS=1, PUT_OUT forced to X at the capture edge → ERR_CNT=1, DONE after edge S+3.
